// File: rtl/can_nios2_dbg_pkg.sv
// can_nios2_dbg_pkg: shared state/command types and jdo field positions
// for the Nios II on-chip debug RAM arbiter.
package can_nios2_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AV_WR,
        ST_AV_RD,
        ST_AV_RDW,
        ST_JT_WR,
        ST_JT_RD,
        ST_JT_RDW
    } state_e;

    // JCMD_LDRD is the read queued by an address load; it must not advance jaddr
    typedef enum logic [1:0] {
        JCMD_NONE,
        JCMD_WR,
        JCMD_RD,
        JCMD_LDRD
    } jcmd_e;

    localparam int JDO_RDREQ   = 35;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_ADDR_LO = 10;

    localparam logic GRANT_JT = 1'b0;
    localparam logic GRANT_AV = 1'b1;

endpackage

// File: rtl/can_nios2_ocimem_jcmd_latch.sv
// can_nios2_ocimem_jcmd_latch: captures one JTAG debug-RAM command at a time,
// flags dropped pulses and owns the auto-incrementing JTAG word address.
module can_nios2_ocimem_jcmd_latch
    import can_nios2_dbg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo_i,
    input  logic              take_a_i,
    input  logic              take_b_i,
    input  logic              take_n_i,
    input  logic              done_i,
    input  logic              inc_i,
    output logic              pend_o,
    output jcmd_e             cmd_o,
    output logic [31:0]       data_o,
    output logic [ADDR_W-1:0] jaddr_o,
    output logic              ovf_o,
    output logic              ready_o
);

    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              ready_q;
    logic              take, accept, load;
    jcmd_e             cmd_q, cmd_d, cmd_new;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo_i[37:36], jdo_i[2:0]};

    // The slot frees on the completing cycle, so a pulse landing there is taken
    always_comb begin
        take    = take_a_i | take_b_i | take_n_i;
        accept  = take && (!pend_q || done_i);
        load    = accept && take_a_i;
        cmd_new = take_a_i ? (jdo_i[JDO_RDREQ] ? JCMD_LDRD : JCMD_NONE) :
                  take_b_i ? JCMD_WR : JCMD_RD;
        cmd_d   = accept ? cmd_new : cmd_q;
        data_d  = accept ? jdo_i[JDO_DATA_HI:JDO_DATA_LO] : data_q;
        pend_d  = (accept && cmd_new != JCMD_NONE) ? 1'b1 : done_i ? 1'b0 : pend_q;
        ovf_d   = (take && !accept) ? 1'b1 : load ? 1'b0 : ovf_q;
        jaddr_d = load  ? jdo_i[ADDR_W+JDO_ADDR_LO-1:JDO_ADDR_LO] :
                  inc_i ? jaddr_q + ADDR_W'(1) : jaddr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            cmd_q   <= JCMD_NONE;
            data_q  <= '0;
            jaddr_q <= '0;
        end else begin
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ready_q <= !pend_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            jaddr_q <= jaddr_d;
        end
    end

    assign pend_o  = pend_q;
    assign cmd_o   = cmd_q;
    assign data_o  = data_q;
    assign jaddr_o = jaddr_q;
    assign ovf_o   = ovf_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/can_nios2_qsys_0_ocimem_arbiter.sv
// can_nios2_qsys_0_ocimem_arbiter: round-robin sharing of the single-port
// debug RAM between the JTAG command path and the CPU Avalon debug slave.
module can_nios2_qsys_0_ocimem_arbiter
    import can_nios2_dbg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_ovf,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              pend, av_req, grant_jt, av_st, jt_st, jt_done, jt_inc;
    jcmd_e             jcmd;
    logic [DATA_W-1:0] jdata;
    logic [ADDR_W-1:0] jaddr;
    logic [DATA_W-1:0] mon_q, mon_d, rdata_q, rdata_d;

    can_nios2_ocimem_jcmd_latch #(.ADDR_W(ADDR_W)) u_jcmd (
        .clk     (clk),
        .reset_n (reset_n),
        .jdo_i   (jdo),
        .take_a_i(take_action_ocimem_a),
        .take_b_i(take_action_ocimem_b),
        .take_n_i(take_no_action_ocimem_a),
        .done_i  (jt_done),
        .inc_i   (jt_inc),
        .pend_o  (pend),
        .cmd_o   (jcmd),
        .data_o  (jdata),
        .jaddr_o (jaddr),
        .ovf_o   (jtag_ovf),
        .ready_o (monitor_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= GRANT_AV;
            mon_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            mon_q   <= mon_d;
            rdata_q <= rdata_d;
        end
    end

    // On a tie the side that was not granted last wins
    always_comb begin
        av_req   = av_read | av_write;
        grant_jt = pend && (!av_req || last_q == GRANT_AV);
        state_d  = state_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_jt) begin
                    state_d = (jcmd == JCMD_WR) ? ST_JT_WR : ST_JT_RD;
                    last_d  = GRANT_JT;
                end else if (av_req) begin
                    state_d = av_write ? ST_AV_WR : ST_AV_RD;
                    last_d  = GRANT_AV;
                end
            end
            ST_AV_RD: state_d = ST_AV_RDW;
            ST_JT_RD: state_d = ST_JT_RDW;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write enable is gated by reset_n directly so a reset can never leave a torn write
    always_comb begin
        av_st          = state_q inside {ST_AV_WR, ST_AV_RD, ST_AV_RDW};
        jt_st          = state_q inside {ST_JT_WR, ST_JT_RD, ST_JT_RDW};
        ram_addr       = av_st ? av_address : jt_st ? jaddr : '0;
        ram_wren       = reset_n && (state_q == ST_AV_WR || state_q == ST_JT_WR);
        ram_byteen     = (state_q == ST_AV_WR) ? av_byteenable : (state_q == ST_JT_WR) ? 4'hF : 4'h0;
        ram_wdata      = (state_q == ST_AV_WR) ? av_writedata : (state_q == ST_JT_WR) ? jdata : '0;
        av_waitrequest = !(state_q == ST_AV_WR || state_q == ST_AV_RDW);
        av_readdata    = (state_q == ST_AV_RDW) ? ram_rdata : rdata_q;
        rdata_d        = (state_q == ST_AV_RDW) ? ram_rdata : rdata_q;
        mon_d          = (state_q == ST_JT_RDW) ? ram_rdata : mon_q;
        jt_done        = state_q == ST_JT_WR || state_q == ST_JT_RDW;
        jt_inc         = jt_done && jcmd != JCMD_LDRD;
    end

    assign MonDReg = mon_q;

endmodule

// File: tb/tb_can_nios2_qsys_0_ocimem_arbiter.sv
// tb_can_nios2_qsys_0_ocimem_arbiter: directed checks of JTAG/Avalon sharing of
// the debug RAM, using a registered-read RAM attached to the RAM port.
module tb_can_nios2_qsys_0_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_ovf;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0, av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [256];
    logic        mem_init = 1'b0;
    int          total = 0;
    int          bad = 0;

    can_nios2_qsys_0_ocimem_arbiter dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .jtag_ovf               (jtag_ovf),
        .av_address             (av_address),
        .av_read                (av_read),
        .av_write               (av_write),
        .av_writedata           (av_writedata),
        .av_byteenable          (av_byteenable),
        .av_readdata            (av_readdata),
        .av_waitrequest         (av_waitrequest),
        .ram_addr               (ram_addr),
        .ram_wren               (ram_wren),
        .ram_byteen             (ram_byteen),
        .ram_wdata              (ram_wdata),
        .ram_rdata              (ram_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as C0DE_00xx so stray addresses are visible
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
            mem_init = 1'b1;
        end
        ram_rdata <= mem[ram_addr];
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    end

    function automatic logic [37:0] jaddr_word(input logic [7:0] a, input logic rd);
        logic [37:0] v = '0;
        v[17:10] = a;
        v[35] = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdata_word(input logic [31:0] d);
        logic [37:0] v = '0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jload(input logic [7:0] a, input logic rd);
        jdo = jaddr_word(a, rd);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jwrite(input logic [31:0] d);
        jdo = jdata_word(d);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jread();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(monitor_ready), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_ovf", 32'(jtag_ovf), 32'd0);
        chk("rst_wait", 32'(av_waitrequest), 32'd1);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_rdata", av_readdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // JTAG write to 0x10, then a sequential read proves jaddr moved to 0x11
        jload(8'h10, 1'b0);
        chk("t1_load_ready", 32'(monitor_ready), 32'd1);
        jwrite(32'hDEADBEEF);
        chk("t1_busy", 32'(monitor_ready), 32'd0);
        tick();
        chk("t1_wren", 32'(ram_wren), 32'd1);
        chk("t1_addr", 32'(ram_addr), 32'h10);
        chk("t1_wdata", ram_wdata, 32'hDEADBEEF);
        chk("t1_byteen", 32'(ram_byteen), 32'hF);
        wait_ready("t1_ready");
        chk("t1_mem", mem[8'h10], 32'hDEADBEEF);
        jread();
        wait_ready("t1_rd_ready");
        chk("t1_mon_next", MonDReg, 32'hC0DE0011);

        // Avalon read: two wait states
        av_address = 8'h10;
        av_read = 1'b1;
        tick();
        chk("t2_wait1", 32'(av_waitrequest), 32'd1);
        tick();
        chk("t2_wait2", 32'(av_waitrequest), 32'd0);
        chk("t2_rdata", av_readdata, 32'hDEADBEEF);
        av_read = 1'b0;
        tick();
        chk("t2_wait_idle", 32'(av_waitrequest), 32'd1);
        chk("t2_rdata_hold", av_readdata, 32'hDEADBEEF);

        // Ties straight after reset: JTAG first, then Avalon
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        jload(8'h30, 1'b0);
        jdo = jdata_word(32'hA1A1A1A1);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        av_write = 1'b1;
        av_address = 8'h20;
        av_writedata = 32'h11112222;
        av_byteenable = 4'b0101;
        tick();
        chk("t3_jt_first_wren", 32'(ram_wren), 32'd1);
        chk("t3_jt_first_addr", 32'(ram_addr), 32'h30);
        chk("t3_av_stalled", 32'(av_waitrequest), 32'd1);
        jdo = jdata_word(32'hA2A2A2A2);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        chk("t3_clear_cycle_ovf", 32'(jtag_ovf), 32'd0);
        chk("t3_idle_wait", 32'(av_waitrequest), 32'd1);
        tick();
        chk("t3_av_second_addr", 32'(ram_addr), 32'h20);
        chk("t3_av_second_wren", 32'(ram_wren), 32'd1);
        chk("t3_av_second_wait", 32'(av_waitrequest), 32'd0);
        chk("t3_av_byteen", 32'(ram_byteen), 32'h5);
        av_write = 1'b0;
        tick();
        tick();
        chk("t3_jt_again_addr", 32'(ram_addr), 32'h31);
        chk("t3_jt_again_wdata", ram_wdata, 32'hA2A2A2A2);
        wait_ready("t3_ready");
        chk("t3_mem30", mem[8'h30], 32'hA1A1A1A1);
        chk("t3_mem20", mem[8'h20], 32'hC0110022);
        chk("t3_mem31", mem[8'h31], 32'hA2A2A2A2);

        // jaddr wraps 0xFF -> 0x00; a load-queued read does not advance jaddr
        jload(8'hFF, 1'b0);
        jread();
        wait_ready("t4_ready_ff");
        chk("t4_mon_ff", MonDReg, 32'hC0DE00FF);
        jread();
        wait_ready("t4_ready_00");
        chk("t4_mon_wrap", MonDReg, 32'hC0DE0000);
        jload(8'h10, 1'b1);
        chk("t4_ldrd_busy", 32'(monitor_ready), 32'd0);
        wait_ready("t4_ldrd_ready");
        chk("t4_ldrd_mon", MonDReg, 32'hDEADBEEF);
        jread();
        wait_ready("t4_noinc_ready");
        chk("t4_noinc_mon", MonDReg, 32'hDEADBEEF);

        // Overrun while Avalon holds the RAM
        jload(8'h40, 1'b0);
        av_address = 8'h10;
        av_read = 1'b1;
        tick();
        jdo = jdata_word(32'hB1B1B1B1);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        chk("t5_av_wait", 32'(av_waitrequest), 32'd0);
        chk("t5_av_rdata", av_readdata, 32'hDEADBEEF);
        av_read = 1'b0;
        jdo = jdata_word(32'hB2B2B2B2);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        chk("t5_ovf_set", 32'(jtag_ovf), 32'd1);
        wait_ready("t5_ready");
        chk("t5_mem40", mem[8'h40], 32'hB1B1B1B1);
        chk("t5_mem41", mem[8'h41], 32'hC0DE0041);
        chk("t5_ovf_sticky", 32'(jtag_ovf), 32'd1);
        jload(8'h50, 1'b0);
        chk("t5_ovf_clear", 32'(jtag_ovf), 32'd0);

        // Reset in the middle of a JTAG write
        jwrite(32'hBADC0FFE);
        tick();
        chk("t6_wren_before", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_wren_killed", 32'(ram_wren), 32'd0);
        chk("t6_mondreg", MonDReg, 32'h0);
        chk("t6_ready", 32'(monitor_ready), 32'd1);
        chk("t6_ovf", 32'(jtag_ovf), 32'd0);
        chk("t6_wait", 32'(av_waitrequest), 32'd1);
        chk("t6_addr", 32'(ram_addr), 32'h0);
        chk("t6_rdata", av_readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_mem50", mem[8'h50], 32'hC0DE0050);
        chk("t6_ready_after", 32'(monitor_ready), 32'd1);
        av_address = 8'h60;
        av_writedata = 32'h600D600D;
        av_byteenable = 4'hF;
        av_write = 1'b1;
        tick();
        chk("t6_avw_wait", 32'(av_waitrequest), 32'd0);
        chk("t6_avw_wren", 32'(ram_wren), 32'd1);
        av_write = 1'b0;
        tick();
        av_read = 1'b1;
        tick();
        tick();
        chk("t6_avr_wait", 32'(av_waitrequest), 32'd0);
        chk("t6_avr_rdata", av_readdata, 32'h600D600D);
        av_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
